// File: rtl/bram_mem_responder.sv
// bram_mem_responder
//   Responder end of the memCtrl request interface backed by on-chip block
//   RAM. It stands in for the PSRAM controller and has a programmable
//   access latency.
//
//   Parameters
//     ADDR_W   stored address bits; depth = 2**ADDR_W bytes
//     LATENCY  cycles o_busy stays high per access (1..15)
//
//   Ports
//     clkSys         system clock, all logic on posedge
//     reset          synchronous reset, active low
//     i_cs           chip select, active low; a request is i_cs==0 while armed
//     i_write        1 = write, 0 = read (sampled at accept)
//     i_address      byte address (sampled at accept); bit ADDR_W-1 and above ignored
//     i_bank         replaces address bit ADDR_W-1
//     i_dataToWrite  write data (sampled at accept)
//     i_flipParity   inverts the stored parity bit (parity build only)
//     o_dataRead     read data, valid while o_dataReady==1
//     o_busy         access in progress
//     o_dataReady    last read completed
//     o_parityErr    parity error on last read (parity build only, else 0)
//
//   Build option
//     BRAM_MEM_RESPONDER_PARITY_EN  9-bit RAM with an even-parity bit
module bram_mem_responder #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clkSys,
   input  logic        reset,
   input  logic        i_cs,
   input  logic        i_write,
   input  logic [23:0] i_address,
   input  logic        i_bank,
   input  logic [7:0]  i_dataToWrite,
   input  logic        i_flipParity,
   output logic [7:0]  o_dataRead,
   output logic        o_busy,
   output logic        o_dataReady,
   output logic        o_parityErr
);

`ifdef BRAM_MEM_RESPONDER_PARITY_EN
   localparam int unsigned MEM_W = 9;
`else
   localparam int unsigned MEM_W = 8;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01
   } state_t;

   state_t              state_q, state_d;
   logic                armed_q, armed_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   ea_q, ea_d;
   logic [MEM_W-1:0]    wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                ready_q, ready_d;
   logic [7:0]          rdata_q, rdata_d;
   logic                perr_q, perr_d;
   logic                mem_we;
   logic [MEM_W-1:0]    mem_rd;
   logic [MEM_W-1:0]    wdata_in;
   logic                unused_ok;

   logic [MEM_W-1:0]    mem [0:(2**ADDR_W)-1];

`ifdef BRAM_MEM_RESPONDER_PARITY_EN
   // Stored word = {even parity ^ inject, data}; XOR over all 9 bits is 0 when intact.
   assign wdata_in  = {^i_dataToWrite ^ i_flipParity, i_dataToWrite};
   assign unused_ok = ^i_address[23:ADDR_W-1];
`else
   assign wdata_in  = i_dataToWrite;
   assign unused_ok = ^{i_flipParity, i_address[23:ADDR_W-1]};
`endif

   assign mem_rd = mem[ea_q];

   always_comb begin
      state_d = state_q;
      armed_d = armed_q | i_cs;
      cnt_d   = cnt_q;
      write_d = write_q;
      ea_d    = ea_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      rdata_d = rdata_q;
      perr_d  = perr_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!i_cs && armed_q) begin
               write_d = i_write;
               ea_d    = {i_bank, i_address[ADDR_W-2:0]};
               wdata_d = wdata_in;
               cnt_d   = 4'(LATENCY - 1);
               armed_d = 1'b0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               perr_d  = 1'b0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
               if (write_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = mem_rd[7:0];
                  ready_d = 1'b1;
`ifdef BRAM_MEM_RESPONDER_PARITY_EN
                  perr_d  = ^mem_rd;
`endif
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clkSys) begin
      if (!reset) begin
         state_q <= S_IDLE;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         write_q <= 1'b0;
         ea_q    <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         ea_q    <= ea_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         perr_q  <= perr_d;
      end
   end

   // RAM has no reset; gating with reset discards a write whose completion edge sees reset.
   always_ff @(posedge clkSys) begin
      if (mem_we && reset) begin
         mem[ea_q] <= wdata_q;
      end
   end

   assign o_busy      = busy_q;
   assign o_dataReady = ready_q;
   assign o_dataRead  = rdata_q;
`ifdef BRAM_MEM_RESPONDER_PARITY_EN
   assign o_parityErr = perr_q;
`else
   assign o_parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_bram_mem_responder.sv
module tb_bram_mem_responder;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned LATENCY = 2;
   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam int unsigned HALF    = DEPTH / 2;

   logic        clkSys = 1'b0;
   logic        reset  = 1'b0;
   logic        i_cs   = 1'b1;
   logic        i_write = 1'b0;
   logic [23:0] i_address = '0;
   logic        i_bank = 1'b0;
   logic [7:0]  i_dataToWrite = '0;
   logic        i_flipParity = 1'b0;
   logic [7:0]  o_dataRead;
   logic        o_busy;
   logic        o_dataReady;
   logic        o_parityErr;

   int checks = 0;
   int errors = 0;

   // reference model: byte store, injected-parity flag, written flag
   logic [7:0] ref_mem  [0:DEPTH-1];
   logic       ref_flip [0:DEPTH-1];
   bit         ref_val  [0:DEPTH-1];
   int         written_q[$];
   logic [7:0] exp_rd = 8'h00;
   logic       exp_rdy = 1'b0;
   logic       exp_perr = 1'b0;

   bram_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clkSys(clkSys), .reset(reset), .i_cs(i_cs), .i_write(i_write),
      .i_address(i_address), .i_bank(i_bank), .i_dataToWrite(i_dataToWrite),
      .i_flipParity(i_flipParity), .o_dataRead(o_dataRead), .o_busy(o_busy),
      .o_dataReady(o_dataReady), .o_parityErr(o_parityErr)
   );

   always #5 clkSys = ~clkSys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ea_of(input logic [23:0] a, input logic b);
      return (b ? HALF : 0) + (int'(a) % HALF);
   endfunction

   function automatic logic exp_parity_err(input logic f);
`ifdef BRAM_MEM_RESPONDER_PARITY_EN
      return f;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, "_busy"}, 32'(o_busy), 32'(0));
      chk({tag, "_rdy"},  32'(o_dataReady), 32'(exp_rdy));
      chk({tag, "_rd"},   32'(o_dataRead), 32'(exp_rd));
      chk({tag, "_perr"}, 32'(o_parityErr), 32'(exp_perr));
   endtask

   // One access from an armed idle state; returns with i_cs released and re-armed.
   task automatic access(input string tag, input logic wr, input logic [23:0] a,
                         input logic b, input logic [7:0] d, input logic f);
      int n;
      int ea;
      @(negedge clkSys);
      i_cs = 1'b0; i_write = wr; i_address = a; i_bank = b;
      i_dataToWrite = d; i_flipParity = f;
      @(negedge clkSys);
      n = 0;
      while (o_busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clkSys);
      end
      chk({tag, "_busylen"}, 32'(n), 32'(LATENCY));
      i_cs = 1'b1;
      ea = ea_of(a, b);
      exp_rdy = 1'b0;
      exp_perr = 1'b0;
      if (wr) begin
         ref_mem[ea] = d; ref_flip[ea] = f;
         if (!ref_val[ea]) written_q.push_back(ea);
         ref_val[ea] = 1'b1;
      end else begin
         exp_rdy = 1'b1;
         exp_rd = ref_mem[ea];
         exp_perr = exp_parity_err(ref_flip[ea]);
      end
      check_outputs(tag);
      @(negedge clkSys);
   endtask

   initial begin
      int rises;
      logic prev;
      reset = 1'b0; i_cs = 1'b1;
      repeat (3) @(negedge clkSys);
      reset = 1'b1;
      repeat (5) @(negedge clkSys);
      check_outputs("reset_idle");

      access("wr_aa", 1'b1, 24'h000001, 1'b0, 8'hAA, 1'b0);
      access("rd_aa", 1'b0, 24'h000001, 1'b0, 8'h00, 1'b0);

      // dataReady drops on accept of a write; dataRead holds
      access("wr_hold", 1'b1, 24'h000002, 1'b0, 8'h5A, 1'b0);

      // CE held low for many cycles: a single access only
      @(negedge clkSys);
      i_cs = 1'b0; i_write = 1'b0; i_address = 24'h000001; i_bank = 1'b0;
      rises = 0; prev = o_busy;
      repeat (22) begin
         @(negedge clkSys);
         if (o_busy === 1'b1 && prev !== 1'b1) rises++;
         prev = o_busy;
      end
      chk("hold_cs_pulses", 32'(rises), 32'(1));
      chk("hold_cs_rd", 32'(o_dataRead), 32'(8'hAA));
      i_cs = 1'b1;
      exp_rdy = 1'b1; exp_rd = 8'hAA; exp_perr = 1'b0;
      @(negedge clkSys);

      // aliasing within a bank and bank separation
      access("pre_b1", 1'b1, 24'h000001, 1'b1, 8'h00, 1'b0);
      access("wr_alias", 1'b1, 24'h000801, 1'b0, 8'h55, 1'b0);
      access("rd_alias", 1'b0, 24'h000001, 1'b0, 8'h00, 1'b0);
      chk("alias_val", 32'(o_dataRead), 32'(8'h55));
      access("rd_bank1", 1'b0, 24'h000001, 1'b1, 8'h00, 1'b0);
      chk("bank1_val", 32'(o_dataRead), 32'(8'h00));

      // reset during a write access discards it
      access("pre_5", 1'b1, 24'h000005, 1'b0, 8'h22, 1'b0);
      @(negedge clkSys);
      i_cs = 1'b0; i_write = 1'b1; i_address = 24'h000005; i_bank = 1'b0;
      i_dataToWrite = 8'h11;
      @(negedge clkSys);
      chk("abort_busy_before", 32'(o_busy), 32'(1));
      reset = 1'b0;
      @(negedge clkSys);
      i_cs = 1'b1;
      exp_rdy = 1'b0; exp_rd = 8'h00; exp_perr = 1'b0;
      check_outputs("abort_reset");
      reset = 1'b1;
      repeat (4) @(negedge clkSys);
      check_outputs("abort_after");
      access("rd_5", 1'b0, 24'h000005, 1'b0, 8'h00, 1'b0);
      chk("abort_val", 32'(o_dataRead), 32'(8'h22));

`ifdef BRAM_MEM_RESPONDER_PARITY_EN
      access("par_wr1", 1'b1, 24'h000010, 1'b0, 8'h3C, 1'b1);
      access("par_rd1", 1'b0, 24'h000010, 1'b0, 8'h00, 1'b0);
      chk("par_err1", 32'(o_parityErr), 32'(1));
      access("par_wr0", 1'b1, 24'h000010, 1'b0, 8'h3C, 1'b0);
      access("par_rd0", 1'b0, 24'h000010, 1'b0, 8'h00, 1'b0);
      chk("par_err0", 32'(o_parityErr), 32'(0));
`endif

      // randomized mix against the model
      for (int k = 0; k < 40; k++) begin
         logic [23:0] a;
         logic        b;
         int          ea;
         if (written_q.size() == 0 || $urandom_range(1, 0) == 1) begin
            a = 24'($urandom);
            b = 1'($urandom);
            access("rnd_wr", 1'b1, a, b, 8'($urandom), 1'($urandom));
         end else begin
            ea = written_q[$urandom_range(written_q.size() - 1, 0)];
            b = (ea >= HALF);
            a = 24'(ea % HALF) | (24'($urandom) << (ADDR_W - 1));
            access("rnd_rd", 1'b0, a, b, 8'h00, 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
